mem_block_mover: RTL

//   Initiator-side controller for the single-port data memory (combinational read,

---
 rtl/mem_block_mover.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_block_mover.sv
// mem_block_mover: block copy/fill engine driving a single-port memory with a registered, glitch-free write strobe
module mem_block_mover #(
  parameter int N = 10,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_fill,
  input  logic [N-1:0] i_src_addr,
  input  logic [N-1:0] i_dst_addr,
  input  logic [N:0]   i_length,
  input  logic [M-1:0] i_fill_value,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_mem_we,
  output logic [N-1:0] o_mem_address,
  output logic [M-1:0] o_mem_write_data,
  input  logic [M-1:0] i_mem_read_data
);
  typedef enum logic [2:0] {IDLE, READ, SETUP, STROBE, HOLD, DONE} state_t;
  state_t       r_state;
  logic         r_fill;
  logic [N-1:0] r_src;
  logic [N-1:0] r_dst;
  logic [N:0]   r_len;
  logic [N:0]   r_idx;
  logic [M-1:0] r_fval;
  logic         r_busy;
  logic         r_done;
  logic         r_we;
  logic [N-1:0] r_addr;
  logic [M-1:0] r_wdata;
  logic [N:0]   w_idx_next;
  logic [N-1:0] w_next_src;
  logic [N-1:0] w_cur_dst;
  assign w_idx_next = r_idx + 1'b1;
  assign w_next_src = r_src + w_idx_next[N-1:0];
  assign w_cur_dst  = r_dst + r_idx[N-1:0];
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_mem_we         = r_we;
  assign o_mem_address    = r_addr;
  assign o_mem_write_data = r_wdata;
  // Sequencer: each word is READ, SETUP, STROBE, HOLD so address/data settle a full cycle around the WE edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fill  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_fval  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_fill <= i_fill;
          r_src  <= i_src_addr;
          r_dst  <= i_dst_addr;
          r_len  <= i_length;
          r_fval <= i_fill_value;
          r_idx  <= '0;
          r_busy <= 1'b1;
          if (i_length == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= READ;
            r_addr  <= i_src_addr;
          end
        end
        READ: begin
          r_wdata <= r_fill ? r_fval : i_mem_read_data;
          r_addr  <= w_cur_dst;
          r_state <= SETUP;
        end
        SETUP: begin
          r_we    <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: r_state <= HOLD;
        HOLD: begin
          r_idx <= w_idx_next;
          if (w_idx_next == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= READ;
            r_addr  <= w_next_src;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
